mmio_timer: RTL and testbench
=============================

# mmio_timer

Memory-mapped down-counting timer that acts as a responder on the CPU data bus (`dm_w`/`dm_r`/`addr`/`wdata`/`dm_op`/`rdata`) and as the source of one `hard_int` line into cop0. It sits beside `peripheral` on the same bus. The CPU programs a preset and control bits with word stores, polls state with loads, and takes an interrupt on expiry. It supports one-shot and auto-reload modes with write-1-to-clear status.

## Interface
- `BASE_ADDR`, default 32'h0000_7F20: register window base, 32-byte aligned; match is `addr[31:5] == BASE_ADDR[31:5]`.
- `CNT_W`, default 32: counter/preset width; registers are zero-extended to 32 bits on read.
- `PRE_W`, default 16: prescaler width; only meaningful with `TIMER_PRESCALE_EN`.
- `clk` in 1: single clock; all state updates on the rising edge.
- `rst` in 1: asynchronous, active-low reset.
- `dm_w` in 1: store strobe; sampled on the rising edge.
- `dm_r` in 1: load strobe.
- `addr` in 32: byte address; `addr[4:2]` selects the register and `addr[1:0]` is ignored.
- `wdata` in 32: store data.
- `dm_op` in 3: access size. It is ignored, and every access is treated as a full word.
- `rdata` out 32: load data; combinational.
- `irq` out 1: level interrupt request to one `hard_int` bit.

## Operation
Register map (offsets from `BASE_ADDR`):
- 0x00 CTRL
  - bit0 EN: run.
  - bit1 IE: interrupt enable.
  - bit2 AUTO: reload on expiry.
  - Other bits read 0.
- 0x04 PRESET: reload value.
- 0x08 COUNT
  - Read returns the live counter.
  - Write loads the counter directly.
- 0x0C STATUS
  - bit0 PEND, read-only except for clearing.
  - Writing 1 to bit0 clears PEND; writing 0 has no effect.
- 0x10 PRESCALE: ticks every PRESCALE+1 clocks.
- 0x14–0x1C: read 0, writes ignored.

State machine, derived from the flops (no separate state register is required):
- **IDLE**: EN=0. The counter holds its value.
- **RUN**: EN=1. The counter decrements by 1 on each tick.
- **Transition IDLE→RUN**: write CTRL with EN=1.
  - If COUNT==0 at that write, COUNT loads PRESET on the same edge.
  - If PRESET==0 as well, EN is forced to 0 and the timer stays IDLE.
- **Expiry**: a tick while COUNT==1. On that edge:
  - PEND is set to 1.
  - If AUTO=1, COUNT loads PRESET and the timer stays in RUN.
  - If AUTO=0, COUNT becomes 0, EN is cleared, and the timer returns to IDLE.
  - An AUTO reload with PRESET==0 clears EN.
- **Return to IDLE by software**: write CTRL with EN=0. COUNT is frozen at its current value.

`irq` = PEND & IE, combinational from flops.

Bus behaviour:
- `rdata` = selected register when `dm_r` is high and the address is in-window; otherwise 32'h0.
- Out-of-window stores are ignored.
- Bits above `CNT_W` are dropped on write.

Simultaneous events:
- A COUNT write and a tick on the same edge: the CPU write wins and no decrement happens.
- A STATUS clear and an expiry on the same edge: the set wins, so PEND stays 1.
- A PRESET write and an AUTO reload on the same edge: the reload uses the old PRESET.
- A CTRL write and an expiry on the same edge: the CTRL write defines EN/IE/AUTO, while PEND is still set.

Counting does not wrap. COUNT never decrements below 0.

## Timing
- Reset values (asynchronous): CTRL=0, PRESET=0, COUNT=0, PEND=0, PRESCALE=0, prescaler counter=0. Therefore `irq`=0, and `rdata`=0 while `dm_r` is low.
- Reset asserted mid-count: all state clears immediately, and `irq` drops without waiting for a clock.
- Store latency: the register updates on the rising edge where `dm_w` is high. A load in the following cycle returns the new value.
- Load latency: zero cycles. `rdata` is valid in the same cycle as `dm_r`, which the single-cycle datapath requires.
- Tick and expiry timing without prescaling:
  - The first tick occurs on the edge after the cycle EN reads 1.
  - With COUNT=N at enable, PEND and `irq` rise N edges after the enabling store edge.
  - AUTO with PRESET=P gives an `irq` period of P clocks.

## Configuration
`TIMER_PRESCALE_EN`:
- **Defined**:
  - The PRESCALE register and a `PRE_W`-bit prescaler counter exist.
  - A tick occurs when the prescaler reaches PRESCALE; the prescaler then resets to 0.
  - The prescaler counts only in RUN and clears on the EN 0→1 transition.
  - Writing PRESCALE also clears the prescaler.
- **Undefined**:
  - A tick occurs on every clock in RUN.
  - Offset 0x10 reads 0 and writes to it are ignored.

## Structure
- The following go in the shared `common.v` include:
  - register offsets (`TMR_CTRL`, `TMR_PRESET`, `TMR_COUNT`, `TMR_STATUS`, `TMR_PRESCALE`);
  - CTRL bit indices (`TMR_EN_BIT`, `TMR_IE_BIT`, `TMR_AUTO_BIT`);
  - the STATUS PEND bit index.
- Sub-module `timer_prescaler` produces a one-cycle `tick` pulse. It is instantiated only under `TIMER_PRESCALE_EN`; otherwise tick = RUN.

## Test plan
- **Reset**:
  - Stimulus: hold `rst`=0, then release it, and read all offsets.
  - Required: 0 everywhere, and `irq`=0.
  - Stimulus: assert `rst`=0 mid-count with PEND=1.
  - Required: `irq` falls asynchronously.
- **One-shot**:
  - Stimulus: PRESET=5; write CTRL=0x3.
  - Required: PEND=1 and `irq`=1 exactly 5 edges later; COUNT=0; CTRL reads 0x2.
  - Stimulus: write STATUS=1.
  - Required: `irq`=0.
- **Auto-reload**:
  - Stimulus: PRESET=3; write CTRL=0x7.
  - Required: PEND sets at edge 3. After clearing STATUS, PEND sets again at edge 6, and COUNT cycles through 2, 1, 3, 2, 1, 3.
- **Collisions**:
  - Stimulus: write COUNT=10 on the same edge a tick occurs.
  - Required: COUNT reads 10.
  - Stimulus: clear STATUS on the expiry edge.
  - Required: PEND remains 1.
- **Decode**:
  - Stimulus: store to `BASE_ADDR`+0x20.
  - Required: no register changes.
  - Stimulus: load any offset with `dm_r`=0.
  - Required: `rdata`=0.
  - Stimulus: sub-word `dm_op` store of 0xAB to PRESET.
  - Required: PRESET=0x0000_00AB as a full word.
- **Prescale** (with `TIMER_PRESCALE_EN` defined):
  - Stimulus: PRESCALE=3, PRESET=2, CTRL=0x3.
  - Required: PEND rises 8 edges after enable.
  - Without the macro: offset 0x10 reads 0, and PEND rises after 2 edges.

Source files
------------

// File: rtl/mmio_timer_pkg.sv
// mmio_timer_pkg: shared definitions for the memory-mapped timer.
//   - Register byte offsets within the 32-byte window.
//   - CTRL and STATUS bit indices.
//   - Run-state encoding, which is derived from CTRL.EN.
package mmio_timer_pkg;

  localparam logic [4:0] TMR_CTRL     = 5'h00;
  localparam logic [4:0] TMR_PRESET   = 5'h04;
  localparam logic [4:0] TMR_COUNT    = 5'h08;
  localparam logic [4:0] TMR_STATUS   = 5'h0C;
  localparam logic [4:0] TMR_PRESCALE = 5'h10;

  localparam int unsigned TMR_EN_BIT   = 0;
  localparam int unsigned TMR_IE_BIT   = 1;
  localparam int unsigned TMR_AUTO_BIT = 2;
  localparam int unsigned TMR_PEND_BIT = 0;

  typedef enum logic {
    TMR_IDLE = 1'b0,
    TMR_RUN  = 1'b1
  } tmr_state_e;

endpackage

// File: rtl/timer_prescaler.sv
// timer_prescaler: divides the clock while the timer runs.
// Produces a one-cycle tick every PRESCALE+1 clocks.
// Ports:
//   clk, rst (async, active-low)
//   run      : timer is in RUN; the counter advances only then
//   clear    : synchronous restart of the divider
//   prescale : terminal count
//   tick     : high in the cycle the divider reaches prescale while running
module timer_prescaler #(
  parameter int unsigned PRE_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             run,
  input  logic             clear,
  input  logic [PRE_W-1:0] prescale,
  output logic             tick
);

  logic [PRE_W-1:0] cnt;

  assign tick = run && (cnt == prescale);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt <= '0;
    end else if (clear) begin
      cnt <= '0;
    end else if (run) begin
      cnt <= tick ? '0 : cnt + PRE_W'(1);
    end
  end

endmodule

// File: rtl/mmio_timer.sv
// mmio_timer: down-counting timer on the CPU data bus.
// It supports one-shot and auto-reload modes.
// Its STATUS.PEND bit is write-1-to-clear.
// Optional feature macro: TIMER_PRESCALE_EN.
//   When defined, it adds the PRESCALE register and the timer_prescaler divider.
//   When undefined, the timer ticks on every clock in RUN.
// Ports:
//   clk, rst (async, active-low)
//   dm_w / dm_r   : store / load strobes
//   addr          : byte address; addr[4:2] selects the register
//   wdata         : store data
//   dm_op         : access size; ignored, all accesses are full words
//   rdata         : combinational load data, 0 unless an in-window load
//   irq           : PEND & IE
module mmio_timer
  import mmio_timer_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR = 32'h0000_7F20,
  parameter int unsigned CNT_W     = 32,
  parameter int unsigned PRE_W     = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        dm_w,
  input  logic        dm_r,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  input  logic [2:0]  dm_op,
  output logic [31:0] rdata,
  output logic        irq
);

  logic             ctrl_en, ctrl_ie, ctrl_auto, pend;
  logic [CNT_W-1:0] preset, count;
  logic             en_nxt, ie_nxt, auto_nxt, pend_nxt;
  logic [CNT_W-1:0] preset_nxt, count_nxt;
  logic             in_win, wr_sel, rd_sel, tick, expire, pre_clear;
  logic [4:0]       off;
  tmr_state_e       state;
  logic             bus_unused;

  assign in_win = (addr[31:5] == BASE_ADDR[31:5]);
  assign wr_sel = dm_w && in_win;
  assign rd_sel = dm_r && in_win;
  assign off    = {addr[4:2], 2'b00};
  assign bus_unused = ^{dm_op, addr[1:0]};

  assign state  = ctrl_en ? TMR_RUN : TMR_IDLE;
  assign expire = tick && (count == CNT_W'(1));
  assign irq    = pend & ctrl_ie;

  // The divider restarts on the IDLE->RUN edge.
  // It also restarts on any PRESCALE store.
  assign pre_clear = wr_sel && (((off == TMR_CTRL) && wdata[TMR_EN_BIT] && (state == TMR_IDLE))
                                || (off == TMR_PRESCALE));

`ifdef TIMER_PRESCALE_EN
  logic [PRE_W-1:0] prescale;
  logic             pre_tick;

  timer_prescaler #(.PRE_W(PRE_W)) u_prescaler (
    .clk      (clk),
    .rst      (rst),
    .run      (state == TMR_RUN),
    .clear    (pre_clear),
    .prescale (prescale),
    .tick     (pre_tick)
  );

  assign tick = pre_tick;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      prescale <= '0;
    end else if (wr_sel && (off == TMR_PRESCALE)) begin
      prescale <= wdata[PRE_W-1:0];
    end
  end
`else
  logic [PRE_W-1:0] prescale_unused;
  logic             pre_clear_unused;
  assign prescale_unused  = '0;
  assign pre_clear_unused = pre_clear;
  assign tick = (state == TMR_RUN);
`endif

  // Later assignments override earlier ones.
  //   - An expiry set of PEND beats a same-edge clear.
  //   - A CPU COUNT store beats a same-edge decrement or reload.
  //   - A CPU CTRL store beats the EN clear from expiry.
  always_comb begin
    en_nxt     = ctrl_en;
    ie_nxt     = ctrl_ie;
    auto_nxt   = ctrl_auto;
    preset_nxt = preset;
    count_nxt  = count;
    pend_nxt   = pend;

    if (tick && (count != '0)) count_nxt = count - CNT_W'(1);

    if (wr_sel && (off == TMR_STATUS) && wdata[TMR_PEND_BIT]) pend_nxt = 1'b0;

    if (expire) begin
      pend_nxt = 1'b1;
      if (ctrl_auto) begin
        count_nxt = preset;
        if (preset == '0) en_nxt = 1'b0;
      end else begin
        en_nxt = 1'b0;
      end
    end

    if (wr_sel) begin
      case (off)
        TMR_CTRL: begin
          en_nxt   = wdata[TMR_EN_BIT];
          ie_nxt   = wdata[TMR_IE_BIT];
          auto_nxt = wdata[TMR_AUTO_BIT];
          if (wdata[TMR_EN_BIT] && (state == TMR_IDLE) && (count == '0)) begin
            if (preset == '0) en_nxt = 1'b0;
            else              count_nxt = preset;
          end
        end
        TMR_PRESET: preset_nxt = wdata[CNT_W-1:0];
        TMR_COUNT:  count_nxt  = wdata[CNT_W-1:0];
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ctrl_en   <= 1'b0;
      ctrl_ie   <= 1'b0;
      ctrl_auto <= 1'b0;
      pend      <= 1'b0;
      preset    <= '0;
      count     <= '0;
    end else begin
      ctrl_en   <= en_nxt;
      ctrl_ie   <= ie_nxt;
      ctrl_auto <= auto_nxt;
      pend      <= pend_nxt;
      preset    <= preset_nxt;
      count     <= count_nxt;
    end
  end

  always_comb begin
    rdata = '0;
    if (rd_sel) begin
      case (off)
        TMR_CTRL:     rdata = 32'({ctrl_auto, ctrl_ie, ctrl_en});
        TMR_PRESET:   rdata = 32'(preset);
        TMR_COUNT:    rdata = 32'(count);
        TMR_STATUS:   rdata = 32'(pend);
`ifdef TIMER_PRESCALE_EN
        TMR_PRESCALE: rdata = 32'(prescale);
`endif
        default:      rdata = '0;
      endcase
    end
  end

endmodule

// File: tb/tb_mmio_timer.sv
// tb_mmio_timer: directed bench for mmio_timer in its default build.
// The default build has TIMER_PRESCALE_EN undefined.
module tb_mmio_timer;

  localparam logic [31:0] BASE = 32'h0000_7F20;

  logic        clk, rst, dm_w, dm_r, irq;
  logic [31:0] addr, wdata, rdata;
  logic [2:0]  dm_op;
  int unsigned n_cmp = 0;
  int unsigned n_bad = 0;

  mmio_timer #(.BASE_ADDR(BASE), .CNT_W(32), .PRE_W(16)) dut (
    .clk   (clk),
    .rst   (rst),
    .dm_w  (dm_w),
    .dm_r  (dm_r),
    .addr  (addr),
    .wdata (wdata),
    .dm_op (dm_op),
    .rdata (rdata),
    .irq   (irq)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic chk_rd(input string tag, input logic [4:0] off, input logic [31:0] exp);
    addr = BASE + 32'(off);
    dm_r = 1'b1;
    #1;
    chk(tag, rdata, exp);
    dm_r = 1'b0;
  endtask

  task automatic wr_abs(input logic [31:0] a, input logic [31:0] d);
    @(negedge clk);
    addr  = a;
    wdata = d;
    dm_w  = 1'b1;
    @(posedge clk);
    #1;
    dm_w  = 1'b0;
  endtask

  task automatic wr(input logic [4:0] off, input logic [31:0] d);
    wr_abs(BASE + 32'(off), d);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b0; dm_w = 1'b0; dm_r = 1'b0;
    addr = BASE; wdata = '0; dm_op = 3'b010;

    // Reset state
    #12;
    chk("rst_irq", 32'(irq), 32'h0);
    chk("rst_rdata_no_rd", rdata, 32'h0);
    @(negedge clk); rst = 1'b1;
    step();
    for (int i = 0; i < 8; i++) chk_rd($sformatf("rst_off%02h", i * 4), 5'(i * 4), 32'h0);
    chk("rst_irq_after", 32'(irq), 32'h0);

    // Decode
    dm_op = 3'b000;
    wr(5'h04, 32'h0000_00AB);
    dm_op = 3'b010;
    chk_rd("subword_preset", 5'h04, 32'h0000_00AB);
    wr_abs(BASE + 32'h20, 32'hFFFF_FFFF);
    chk_rd("oow_ctrl", 5'h00, 32'h0);
    chk_rd("oow_preset", 5'h04, 32'h0000_00AB);
    chk_rd("oow_count", 5'h08, 32'h0);
    wr(5'h14, 32'hFFFF_FFFF);
    chk_rd("reserved14", 5'h14, 32'h0);
    addr = BASE + 32'h04; dm_r = 1'b0; #1;
    chk("rd_low_rdata", rdata, 32'h0);
    wr(5'h10, 32'h3);
    chk_rd("prescale_absent", 5'h10, 32'h0);

    // One-shot: PRESET=5, CTRL=IE|EN
    wr(5'h04, 32'd5);
    wr(5'h00, 32'h3);
    chk_rd("os_count_load", 5'h08, 32'd5);
    repeat (4) step();
    chk_rd("os_count_e4", 5'h08, 32'd1);
    chk("os_irq_e4", 32'(irq), 32'h0);
    step();
    chk("os_irq_e5", 32'(irq), 32'h1);
    chk_rd("os_pend_e5", 5'h0C, 32'h1);
    chk_rd("os_count_e5", 5'h08, 32'h0);
    chk_rd("os_ctrl_e5", 5'h00, 32'h2);
    step();
    chk_rd("os_count_idle", 5'h08, 32'h0);
    wr(5'h0C, 32'h0);
    chk_rd("os_w0_noclear", 5'h0C, 32'h1);
    wr(5'h0C, 32'h1);
    chk("os_irq_cleared", 32'(irq), 32'h0);
    chk_rd("os_pend_cleared", 5'h0C, 32'h0);

    // Auto-reload: PRESET=3, CTRL=AUTO|IE|EN
    wr(5'h04, 32'd3);
    wr(5'h00, 32'h7);
    step(); chk_rd("ar_e1", 5'h08, 32'd2);
    step(); chk_rd("ar_e2", 5'h08, 32'd1);
    chk_rd("ar_pend_e2", 5'h0C, 32'h0);
    step(); chk_rd("ar_e3", 5'h08, 32'd3);
    chk_rd("ar_pend_e3", 5'h0C, 32'h1);
    chk("ar_irq_e3", 32'(irq), 32'h1);
    wr(5'h0C, 32'h1);
    chk_rd("ar_e4", 5'h08, 32'd2);
    chk_rd("ar_pend_e4", 5'h0C, 32'h0);
    step(); chk_rd("ar_e5", 5'h08, 32'd1);
    step(); chk_rd("ar_e6", 5'h08, 32'd3);
    chk_rd("ar_pend_e6", 5'h0C, 32'h1);
    chk_rd("ar_ctrl_e6", 5'h00, 32'h7);

    // Collisions
    step(); step();
    chk_rd("col_pre_exp", 5'h08, 32'd1);
    wr(5'h0C, 32'h1);
    chk_rd("col_clear_vs_set", 5'h0C, 32'h1);
    chk_rd("col_reload", 5'h08, 32'd3);
    wr(5'h08, 32'd10);
    chk_rd("col_count_wr", 5'h08, 32'd10);

    // Software stop, then COUNT holds while idle
    wr(5'h00, 32'h0);
    wr(5'h0C, 32'h1);
    wr(5'h08, 32'd20);
    repeat (3) step();
    chk_rd("idle_hold", 5'h08, 32'd20);
    chk_rd("idle_pend", 5'h0C, 32'h0);

    // Enable with COUNT==0 and PRESET==0 leaves EN clear
    wr(5'h08, 32'h0);
    wr(5'h04, 32'h0);
    wr(5'h00, 32'h3);
    chk_rd("zero_preset_ctrl", 5'h00, 32'h2);
    step();
    chk_rd("zero_preset_count", 5'h08, 32'h0);
    chk("zero_preset_irq", 32'(irq), 32'h0);

    // Asynchronous reset while counting with PEND set
    wr(5'h04, 32'd2);
    wr(5'h00, 32'h7);
    step();
    step();
    chk("ares_irq_before", 32'(irq), 32'h1);
    #2;
    rst = 1'b0;
    #1;
    chk("ares_irq_drop", 32'(irq), 32'h0);
    chk_rd("ares_count", 5'h08, 32'h0);
    chk_rd("ares_ctrl", 5'h00, 32'h0);
    chk_rd("ares_preset", 5'h04, 32'h0);
    @(negedge clk); rst = 1'b1;
    step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
